mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning: consecutive lost arbitrations after which fetch wins.
REQ-002 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have fetch ports i_if_req in 1, i_if_addr in 16, o_if_gnt out 1, o_if_rvalid out 1, o_if_rdata out 32.
REQ-005 SHALL have load/store ports i_ls_req in 1, i_ls_addr in 16, i_ls_wdata in 32, i_ls_mask in 4, i_ls_wren in 1, o_ls_gnt out 1, o_ls_rvalid out 1, o_ls_rdata out 32.
REQ-006 SHALL have memory ports o_mem_addr out 16, o_mem_wdata out 32, o_mem_mask out 4, o_mem_wren out 1, i_mem_rdata in 32 (combinational read, byte lanes masked, write on clock edge).
REQ-007 SHALL have o_busy out 1, high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight at a time.
REQ-009 SHALL, in IDLE with any request, assert exactly one grant combinationally; at that edge latch winner's addr/wdata/mask/wren and owner ID, go to ACCESS.
REQ-010 SHALL give load/store priority over fetch, unless starve counter == STARVE_LIMIT, then fetch wins.
REQ-011 SHALL increment starve counter (saturating at STARVE_LIMIT) on each grant to load/store while i_if_req high; clear on fetch grant or i_if_req low in IDLE.
REQ-012 SHALL latch fetch transactions as mask 4'hF, wren 0, wdata 0.
REQ-013 SHALL, in ACCESS only, drive o_mem_addr/wdata/mask from latched values and o_mem_wren = latched wren; capture i_mem_rdata into a response register at end of ACCESS.
REQ-014 SHALL, outside ACCESS, drive o_mem_mask 4'h0, o_mem_wren 0, o_mem_addr and o_mem_wdata 0.
REQ-015 SHALL, in RESP, pulse owner's rvalid for exactly one cycle with captured data; writes also acknowledged, rdata = 32'h0.
REQ-016 SHALL hold non-owner rvalid low and both rdata outputs at last driven value only while its rvalid is high, 0 otherwise.
REQ-017 SHALL keep both grants low outside IDLE; requesters hold req and payload until granted.
REQ-018 SHALL give latency: grant cycle N, memory access N+1, rvalid N+2; next grant earliest N+3.
REQ-019 SHALL pass addresses unmodified; wrap of addr+1..+3 beyond 16'hFFFF is memory's concern.
REQ-020 SHALL treat a load/store with mask 4'h0 as a legal no-op returning rdata 0.
REQ-021 SHALL ignore request deassertion after grant; the latched transaction completes.

Reset
REQ-022 SHALL, on i_reset high, immediately force state IDLE, starve counter 0, latched registers 0, all grants/rvalids 0, rdata 0, memory controls per REQ-014.
REQ-023 SHALL abort any in-flight transaction on reset: no rvalid issued; a write reaches memory only if its ACCESS edge preceded reset assertion.
REQ-024 SHALL take first grant no earlier than first rising edge after i_reset deasserts.

Verification
REQ-025 SHALL cover fetch-only read: i_if_addr 16'h0010 held -> o_if_gnt cycle N, o_mem_addr 16'h0010 mask F cycle N+1, o_if_rvalid with word at N+2.
REQ-026 SHALL cover store then load: ls write addr 16'h0100 wdata 32'hDEADBEEF mask 4'h3 -> ack rdata 0; then load mask F -> o_ls_rdata 32'h0000BEEF.
REQ-027 SHALL cover simultaneous requests: both req in same cycle -> o_ls_gnt first, o_if_gnt at N+3.
REQ-028 SHALL cover starvation: i_ls_req and i_if_req held high -> after 4 ls grants the 5th grant is fetch, counter then 0.
REQ-029 SHALL cover reset during ACCESS of a write: i_reset asserted mid-ACCESS cycle -> o_mem_wren 0 immediately, no rvalid, o_busy 0, target bytes unchanged.
REQ-030 SHALL cover mask 4'h0 load -> o_ls_rvalid at N+2 with rdata 32'h0, o_mem_wren never high.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Two-master arbiter in front of a single-port memory. It serves an
//   instruction-fetch master (read only) and a load/store master (read/write
//   with byte mask). Only one transaction is in flight at a time:
//   IDLE (grant) -> ACCESS (memory strobe) -> RESP (rvalid pulse) -> IDLE.
//   Load/store has priority. Fetch wins anyway once it has lost
//   STARVE_LIMIT consecutive arbitrations.
//
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_if_req, i_if_addr     fetch request and word address
//   o_if_gnt                fetch grant (combinational, IDLE only)
//   o_if_rvalid, o_if_rdata fetch response (one-cycle pulse in RESP)
//   i_ls_req, i_ls_addr,    load/store request, address, write data,
//   i_ls_wdata, i_ls_mask,  byte mask and write enable
//   i_ls_wren
//   o_ls_gnt                load/store grant (combinational, IDLE only)
//   o_ls_rvalid, o_ls_rdata load/store response (writes return 0)
//   o_mem_addr, o_mem_wdata,
//   o_mem_mask, o_mem_wren  memory strobes, active during ACCESS only
//   i_mem_rdata             combinational memory read data
//   o_busy                  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,

    input  logic        i_ls_req,
    input  logic [15:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_mask,
    input  logic        i_ls_wren,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,

    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata,

    output logic        o_busy
);

    // The counter must hold the value STARVE_LIMIT itself.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    state_t           state_q,  state_d;
    owner_t           owner_q,  owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [15:0]      addr_q,   addr_d;
    logic [31:0]      wdata_q,  wdata_d;
    logic [3:0]       mask_q,   mask_d;
    logic             wren_q,   wren_d;
    logic [31:0]      resp_q,   resp_d;

    logic             arb_open;
    logic             fetch_wins;
    logic             in_access;
    logic             in_resp;

    // Expand a byte mask to a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

    // Increment that sticks at STARVE_LIMIT.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == STARVE_MAX) ? c : c + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration (combinational, only meaningful in IDLE)
    // ------------------------------------------------------------------
    // Gating with i_reset keeps both grants low while reset is held even
    // though the state register already reads IDLE.
    assign arb_open   = (state_q == IDLE) && !i_reset;
    assign fetch_wins = i_if_req && (!i_ls_req || (starve_q == STARVE_MAX));
    assign o_if_gnt   = arb_open && fetch_wins;
    assign o_ls_gnt   = arb_open && i_ls_req && !fetch_wins;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        wren_d   = wren_q;
        resp_d   = resp_q;

        unique case (state_q)
            IDLE: begin
                // Fetch not asking means it is not being starved.
                if (!i_if_req) begin
                    starve_d = '0;
                end

                if (o_if_gnt) begin
                    state_d  = ACCESS;
                    owner_d  = OWN_IF;
                    addr_d   = i_if_addr;
                    wdata_d  = '0;
                    mask_d   = 4'hF;
                    wren_d   = 1'b0;
                    starve_d = '0;
                end else if (o_ls_gnt) begin
                    state_d  = ACCESS;
                    owner_d  = OWN_LS;
                    addr_d   = i_ls_addr;
                    wdata_d  = i_ls_wdata;
                    mask_d   = i_ls_mask;
                    wren_d   = i_ls_wren;
                    if (i_if_req) begin
                        starve_d = sat_inc(starve_q);
                    end
                end
            end

            ACCESS: begin
                // Only enabled lanes are returned; a write acknowledges
                // with zero and a zero mask reads as zero.
                resp_d  = wren_q ? 32'h0 : (i_mem_rdata & lane_mask(mask_q));
                state_d = RESP;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            wren_q   <= 1'b0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            wren_q   <= wren_d;
            resp_q   <= resp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------
    // Reset forces state_q to IDLE asynchronously, so the memory strobes
    // and rvalids drop in the same instant reset rises.
    assign in_access   = (state_q == ACCESS);
    assign in_resp     = (state_q == RESP);

    assign o_busy      = (state_q != IDLE);

    assign o_mem_addr  = in_access ? addr_q  : 16'h0;
    assign o_mem_wdata = in_access ? wdata_q : 32'h0;
    assign o_mem_mask  = in_access ? mask_q  : 4'h0;
    assign o_mem_wren  = in_access && wren_q;

    assign o_if_rvalid = in_resp && (owner_q == OWN_IF);
    assign o_ls_rvalid = in_resp && (owner_q == OWN_LS);
    assign o_if_rdata  = o_if_rvalid ? resp_q : 32'h0;
    assign o_ls_rdata  = o_ls_rvalid ? resp_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic [15:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_mask;
    logic        ls_wren;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_wren;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_ls_req    (ls_req),
        .i_ls_addr   (ls_addr),
        .i_ls_wdata  (ls_wdata),
        .i_ls_mask   (ls_mask),
        .i_ls_wren   (ls_wren),
        .o_ls_gnt    (ls_gnt),
        .o_ls_rvalid (ls_rvalid),
        .o_ls_rdata  (ls_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_mask  (mem_mask),
        .o_mem_wren  (mem_wren),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int rv_seen = 0;

    typedef struct packed {
        logic        is_ls;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // Memory model: combinational masked read, byte-lane write on clock edge.
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    function automatic exp_t mk(input logic is_ls, input logic [31:0] d);
        exp_t x;
        x.is_ls = is_ls;
        x.data  = d;
        return x;
    endfunction

    always_comb mem_rdata = mem[mem_addr] & lanes(mem_mask);

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Scoreboard: every rvalid pops the oldest expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_rvalid || ls_rvalid) begin
                rv_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rvalid got if=%0b ls=%0b required none", if_rvalid, ls_rvalid);
                end else begin
                    e = sb.pop_front();
                    if ({ls_rvalid, if_rvalid} !== {e.is_ls, ~e.is_ls} ||
                        (e.is_ls ? ls_rdata : if_rdata) !== e.data) begin
                        errors++;
                        $display("FAIL sb_response got ls=%0b if=%0b data=%h required ls=%0b data=%h",
                                 ls_rvalid, if_rvalid, e.is_ls ? ls_rdata : if_rdata, e.is_ls, e.data);
                    end
                end
            end
            checks++;
            if ((!if_rvalid && if_rdata !== 32'h0) || (!ls_rvalid && ls_rdata !== 32'h0)) begin
                errors++;
                $display("FAIL idle_rdata got if=%h ls=%h required 0", if_rdata, ls_rdata);
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Drives a load/store until granted; returns negedges waited (-1 on timeout).
    // Returns 1ns after the grant edge, i.e. inside the ACCESS cycle.
    task automatic issue_ls(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                            input logic w, input bit expect_resp, output int g);
        ls_addr = a; ls_wdata = d; ls_mask = m; ls_wren = w; ls_req = 1'b1;
        g = -1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (ls_gnt === 1'b1) begin
                g = i;
                break;
            end
        end
        if (g >= 0 && expect_resp) begin
            sb.push_back(mk(1'b1, w ? 32'h0 : (ref_mem[a] & lanes(m))));
            if (w) for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clk);
        #1 ls_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if_req = 0; if_addr = 0; ls_req = 0; ls_addr = 0; ls_wdata = 0; ls_mask = 0; ls_wren = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy, mem_wren} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy, mem_wren});
        end
        checks++;
        if (mem_mask !== 4'h0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got mask=%h addr=%h wdata=%h required 0", mem_mask, mem_addr, mem_wdata);
        end
        checks++;
        if (if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got if=%h ls=%h required 0", if_rdata, ls_rdata);
        end
        // Requests held during reset must neither be granted nor start a transaction.
        if_req = 1'b1; if_addr = 16'h0010; ls_req = 1'b1; ls_addr = 16'h0010; ls_mask = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt got if=%b ls=%b required 0", if_gnt, ls_gnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b required 0", busy);
        end
        if_req = 1'b0; ls_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_fetch_read;
        preload(16'h0010, 32'h1234_5678);
        if_addr = 16'h0010; if_req = 1'b1;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt got if=%b ls=%b required if=1 ls=0", if_gnt, ls_gnt);
        end
        sb.push_back(mk(1'b0, ref_mem[16'h0010]));
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h0010 || mem_mask !== 4'hF || mem_wren !== 1'b0 || busy !== 1'b1 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_access got addr=%h mask=%h wren=%b busy=%b gnt=%b required 0010 f 0 1 0",
                     mem_addr, mem_mask, mem_wren, busy, if_gnt);
        end
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fetch_rvalid got %b data=%h required 1 12345678", if_rvalid, if_rdata);
        end
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse got rvalid=%b busy=%b required 0 0", if_rvalid, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [1:0] mid;
        if_addr = 16'h0010; if_req = 1'b1;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_gnt got %b required 1", if_gnt);
        end
        sb.push_back(mk(1'b0, ref_mem[16'h0010]));
        @(negedge clk); mid[0] = if_gnt;
        @(negedge clk); mid[1] = if_gnt;
        checks++;
        if (mid !== 2'b00) begin
            errors++;
            $display("FAIL b2b_gap got %b required 00", mid);
        end
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_gnt got %b required 1", if_gnt);
        end
        sb.push_back(mk(1'b0, ref_mem[16'h0010]));
        @(posedge clk);
        #1 if_req = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load;
        int g;
        preload(16'h0100, 32'h0);
        issue_ls(16'h0100, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b1, g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL store_gnt got wait=%0d required 0", g);
        end
        @(negedge clk);
        checks++;
        if (mem_wren !== 1'b1 || mem_mask !== 4'h3 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL store_access got wren=%b mask=%h wdata=%h addr=%h required 1 3 deadbeef 0100",
                     mem_wren, mem_mask, mem_wdata, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL store_ack got rvalid=%b data=%h required 1 0", ls_rvalid, ls_rdata);
        end
        @(posedge clk);
        #1;
        issue_ls(16'h0100, 32'h0, 4'hF, 1'b0, 1'b1, g);
        repeat (2) @(negedge clk);
        checks++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL load_data got rvalid=%b data=%h required 1 0000beef", ls_rvalid, ls_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mask_zero;
        int g;
        issue_ls(16'h0100, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("FAIL mask0_gnt got wait=%0d required 0", g);
        end
        @(negedge clk);
        checks++;
        if (mem_wren !== 1'b0 || mem_mask !== 4'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mask0_access got wren=%b mask=%h busy=%b required 0 0 1", mem_wren, mem_mask, busy);
        end
        @(negedge clk);
        checks++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0 || mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL mask0_resp got rvalid=%b data=%h wren=%b required 1 0 0", ls_rvalid, ls_rdata, mem_wren);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous;
        logic [2:0] later;
        preload(16'h0300, 32'hA5A5_0003);
        preload(16'h0020, 32'h0BAD_F00D);
        if_addr = 16'h0020; if_req = 1'b1;
        ls_addr = 16'h0300; ls_wdata = 0; ls_mask = 4'hF; ls_wren = 1'b0; ls_req = 1'b1;
        @(negedge clk);
        checks++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL simul_first got ls=%b if=%b required 1 0", ls_gnt, if_gnt);
        end
        sb.push_back(mk(1'b1, ref_mem[16'h0300]));
        @(posedge clk);
        #1 ls_req = 1'b0;
        @(negedge clk); later[0] = if_gnt;
        @(negedge clk); later[1] = if_gnt;
        @(negedge clk); later[2] = if_gnt;
        checks++;
        if (later !== 3'b100) begin
            errors++;
            $display("FAIL simul_fetch_n3 got %b required 100", later);
        end
        sb.push_back(mk(1'b0, ref_mem[16'h0020]));
        @(posedge clk);
        #1 if_req = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_starvation;
        logic [9:0] exp_fetch;
        logic       got_fetch;
        bit         seen;
        exp_fetch = 10'b10_0001_0000;
        preload(16'h0400, 32'h4444_0000);
        preload(16'h0030, 32'h3030_3030);
        if_addr = 16'h0030; if_req = 1'b1;
        ls_addr = 16'h0400; ls_wdata = 0; ls_mask = 4'hF; ls_wren = 1'b0; ls_req = 1'b1;
        for (int n = 0; n < 10; n++) begin
            seen = 1'b0;
            got_fetch = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (if_gnt === 1'b1 || ls_gnt === 1'b1) begin
                    seen = 1'b1;
                    got_fetch = if_gnt;
                    break;
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL starve_timeout grant %0d got none required one", n);
            end else if (got_fetch !== exp_fetch[n]) begin
                errors++;
                $display("FAIL starve_grant %0d got fetch=%b required fetch=%b", n, got_fetch, exp_fetch[n]);
            end
            if (seen) sb.push_back(got_fetch ? mk(1'b0, ref_mem[16'h0030]) : mk(1'b1, ref_mem[16'h0400]));
            @(posedge clk);
            #1;
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_access;
        int g;
        int base;
        preload(16'h0200, 32'h1111_1111);
        base = rv_seen;
        issue_ls(16'h0200, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, g);
        checks++;
        if (g !== 0 || mem_wren !== 1'b1) begin
            errors++;
            $display("FAIL rstacc_access got wait=%0d wren=%b required 0 1", g, mem_wren);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_wren !== 1'b0 || busy !== 1'b0 || mem_mask !== 4'h0 || ls_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstacc_immediate got wren=%b busy=%b mask=%h rvalid=%b required 0 0 0 0",
                     mem_wren, busy, mem_mask, ls_rvalid);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rv_seen !== base) begin
            errors++;
            $display("FAIL rstacc_no_rvalid got %0d rvalids required 0", rv_seen - base);
        end
        checks++;
        if (mem[16'h0200] !== 32'h1111_1111) begin
            errors++;
            $display("FAIL rstacc_mem got %h required 11111111", mem[16'h0200]);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_back_to_back();
        test_store_load();
        test_mask_zero();
        test_simultaneous();
        test_starvation();
        test_reset_access();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d outstanding required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
